bridge_uart_responder: RTL and testbench
========================================

Name: bridge_uart_responder

Overview:
Responder (slave) end of the 9-bit-address, 32-bit-data bridge bus that the JTAG UART monitor drives as initiator. It decodes the JTAG-UART-compatible register map (DATA, CONTROL) behind an acknowledge handshake with configurable wait states. It buffers bytes in TX/RX FIFOs that connect to byte-stream ports on the serial side. Used to close the bridge loop in simulation and as an on-chip console endpoint.

Parameters:
FIFO_DEPTH, 64, entries per FIFO; power of two, 2..1024
WAIT_STATES, 0, extra cycles inserted before acknowledge; range 0..15

Ports:
clk  input  1  single clock for all logic
reset  input  1  asynchronous, active-high reset
bridge_read  input  1  read request; initiator holds it until acknowledge
bridge_write  input  1  write request; initiator holds it until acknowledge
bridge_byte_enable  input  4  write byte lanes
bridge_address  input  9  byte address
bridge_write_data  input  32  write data
bridge_acknowledge  output  1  one-cycle completion pulse
bridge_read_data  output  32  read data; valid only in the acknowledge cycle
tx_data  output  8  TX FIFO head byte
tx_valid  output  1  TX FIFO not empty
tx_ready  input  1  consumer accepts tx_data when tx_valid && tx_ready
rx_data  input  8  incoming byte
rx_valid  input  1  incoming byte present
rx_ready  output  1  RX FIFO not full
irq  output  1  level interrupt

Behaviour:
- Reset state:
  - acknowledge = 0, read_data = 0, irq = 0.
  - Both FIFOs empty, so tx_valid = 0 and rx_ready = 1.
  - CONTROL register = 0; FSM in IDLE.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on (read | write) sampled high, latch address, byte_enable, write_data and request type.
    - Go to WAIT if WAIT_STATES > 0, else to ACK.
    - Read and write both high: handled as a write only.
  - WAIT: count WAIT_STATES cycles, then go to ACK.
  - ACK: acknowledge = 1 for exactly one cycle; all side effects commit on this cycle; then return to IDLE.
- Latency: acknowledge is asserted WAIT_STATES+1 cycles after the request is first sampled.
  - Initiator drops the request on the edge where it sees acknowledge.
  - A request seen high again in IDLE starts a new transaction, so back-to-back transactions cost WAIT_STATES+2 cycles.
- Address decode uses bits [8:2]. Word 0 is DATA, word 1 is CONTROL; all other words read 0, ignore writes, and still acknowledge.
- DATA read returns:
  - {RAVAIL[15:0], RVALID, 7'b0, byte}.
  - RVALID = RX FIFO non-empty. RAVAIL = occupancy after the pop.
  - Pops one RX entry if RVALID. When empty, returns byte = 0 and RVALID = 0.
- DATA write with byte_enable[0] pushes write_data[7:0] into the TX FIFO.
  - If the TX FIFO is full, the byte is silently dropped and acknowledge still occurs.
  - Byte lanes [3:1] are ignored.
- CONTROL read returns {WSPACE[15:0], 5'b0, AC, WI, RI, 6'b0, WE, RE}.
  - WSPACE = free TX entries.
  - RI = RE && RX non-empty. WI = WE && (TX occupancy <= FIFO_DEPTH/2).
- CONTROL write:
  - Lane 0 updates RE (bit 0) and WE (bit 1).
  - Lane 1 writing 1 to bit 10 clears AC; AC is a sticky flag set whenever a TX byte is consumed.
- irq = RI | WI, registered, so it follows its cause by one cycle.
- FIFOs:
  - TX pops on tx_valid && tx_ready. RX pushes on rx_valid && rx_ready.
  - Simultaneous push and pop at the same FIFO in one cycle is legal and leaves occupancy unchanged.
  - Full push with a simultaneous pop succeeds.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counters are log2(FIFO_DEPTH)+1 bits wide.
- Reset asserted mid-transaction: the transaction is aborted with no acknowledge, FIFOs are flushed, and the FSM returns to IDLE. The initiator must retry.

Optional Feature:
BRIDGE_UART_LOOPBACK_EN
- Defined:
  - CONTROL bit 3 (LB, lane 0, reset value 0) exists and reads back.
  - When LB = 1: the TX FIFO head feeds the RX FIFO internally, moving one byte per cycle whenever TX is non-empty and RX is non-full.
  - Also when LB = 1: tx_valid is forced to 0 and rx_ready is forced to 0.
- Undefined: bit 3 reads 0, writes to it are ignored, and there is no internal path.

Test Plan:
- WAIT_STATES = 0: read CONTROL after reset -> acknowledge 1 cycle after the request, read_data = 0x0040_0000 (WSPACE = 64).
- Write 0x41 to DATA with byte_enable = 4'b0001, tx_ready = 0 -> tx_valid = 1, tx_data = 0x41, WSPACE reads 63. Then tx_ready = 1 -> AC = 1.
- Drive rx bytes 0x10 and 0x11, then two DATA reads -> 0x0001_8010, then 0x0000_8011. A third read -> 0x0000_0000.
- Fill TX with 64 writes, then write a 65th (0xFF) -> acknowledged, and 0xFF never appears on tx_data. WSPACE = 0.
- WAIT_STATES = 3: read at 0x1FC -> acknowledge 4 cycles after the request, data 0. Read and write asserted together -> exactly one acknowledge, and the write takes effect.
- RE = 1 with one RX byte -> irq = 1. Pop the byte -> irq = 0 one cycle after acknowledge. With the macro defined, LB = 1 and write 0x5A -> a DATA read returns 0x0000_805A.

Source files
------------

// File: rtl/bridge_uart_responder.sv
// Bridge-bus responder with a JTAG-UART-compatible register map (DATA, CONTROL).
// Bytes are buffered in TX and RX FIFOs behind byte-stream ports. Each
// transaction is acknowledged after WAIT_STATES extra cycles.
//
// Optional feature macro: BRIDGE_UART_LOOPBACK_EN. When it is defined,
// CONTROL bit 3 (LB) exists, and setting it routes the TX FIFO head into
// the RX FIFO.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   bridge_read/write     request, held by the initiator until acknowledge
//   bridge_byte_enable    write byte lanes
//   bridge_address        byte address; word index taken from bits [8:2]
//   bridge_write_data     write data
//   bridge_acknowledge    one-cycle completion pulse
//   bridge_read_data      read data, valid in the acknowledge cycle
//   tx_data/valid/ready   TX FIFO head byte stream
//   rx_data/valid/ready   RX FIFO input byte stream
//   irq                   level interrupt, RI | WI registered
module bridge_uart_responder #(
   parameter int unsigned FIFO_DEPTH  = 64,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bridge_read,
   input  logic        bridge_write,
   input  logic [3:0]  bridge_byte_enable,
   input  logic [8:0]  bridge_address,
   input  logic [31:0] bridge_write_data,
   output logic        bridge_acknowledge,
   output logic [31:0] bridge_read_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        irq
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned WW = 4;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_C  = CW'(FIFO_DEPTH / 2);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t        state, state_next;
   logic [WW-1:0] wait_cnt, wait_cnt_next;
   logic          commit_c;

   // Request fields latched in IDLE
   logic          lat_write;
   logic [1:0]    lat_be;
   logic [6:0]    lat_word;
   logic [7:0]    lat_wbyte;
   logic          lat_ac_clr;

   // Fields used at commit: live inputs when committing straight from IDLE
   logic          req_write;
   logic [1:0]    req_be;
   logic [6:0]    req_word;
   logic [7:0]    req_wbyte;
   logic          req_ac_clr;

   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
   logic [CW-1:0] tx_count, rx_count;
   logic          tx_push, tx_pop, rx_push, rx_pop, lb_move;
   logic [7:0]    rx_in_byte;
   logic          re, we, ac, ri, wi;
   logic [31:0]   read_data_next;

`ifdef BRIDGE_UART_LOOPBACK_EN
   logic          lb;
`else
   logic          lb;
   assign lb = 1'b0;
`endif

   logic unused_inputs;
   assign unused_inputs = ^{bridge_byte_enable[3:2], bridge_address[1:0],
                            bridge_write_data[31:11], bridge_write_data[9:8]};

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Next state; commit_c marks the edge that enters ACK
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      commit_c      = 1'b0;
      case (state)
         S_IDLE: begin
            if (bridge_read || bridge_write) begin
               if (WAIT_STATES == 0) begin
                  state_next = S_ACK;
                  commit_c   = 1'b1;
               end else begin
                  state_next    = S_WAIT;
                  wait_cnt_next = '0;
               end
            end
         end
         S_WAIT: begin
            if (wait_cnt == WW'(WAIT_STATES - 1)) begin
               state_next = S_ACK;
               commit_c   = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt + WW'(1);
            end
         end
         S_ACK:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Commit-time request fields
   always_comb begin
      if (state == S_IDLE) begin
         req_write  = bridge_write;
         req_be     = bridge_byte_enable[1:0];
         req_word   = bridge_address[8:2];
         req_wbyte  = bridge_write_data[7:0];
         req_ac_clr = bridge_write_data[10];
      end else begin
         req_write  = lat_write;
         req_be     = lat_be;
         req_word   = lat_word;
         req_wbyte  = lat_wbyte;
         req_ac_clr = lat_ac_clr;
      end
   end

   assign tx_valid = !lb && (tx_count != '0);
   assign rx_ready = !lb && (rx_count != DEPTH_C);
   assign tx_data  = tx_mem[tx_rd_ptr];
   assign ri       = re && (rx_count != '0);
   assign wi       = we && (tx_count <= HALF_C);

   // FIFO handshakes; a full TX FIFO still accepts a push when it pops in the same cycle
   always_comb begin
      lb_move    = lb && (tx_count != '0) && (rx_count != DEPTH_C);
      tx_pop     = (tx_valid && tx_ready) || lb_move;
      rx_push    = (rx_valid && rx_ready) || lb_move;
      rx_in_byte = lb_move ? tx_mem[tx_rd_ptr] : rx_data;
      rx_pop     = commit_c && !req_write && (req_word == 7'd0) && (rx_count != '0);
      tx_push    = commit_c && req_write && (req_word == 7'd0) && req_be[0]
                   && ((tx_count != DEPTH_C) || tx_pop);
   end

   // Read data for the acknowledge cycle
   always_comb begin
      read_data_next = '0;
      if (commit_c && !req_write) begin
         case (req_word)
            7'd0: read_data_next = {16'(rx_count - CW'(rx_pop)), (rx_count != '0), 7'b0,
                                    (rx_count != '0) ? rx_mem[rx_rd_ptr] : 8'h00};
            7'd1: read_data_next = {16'(DEPTH_C - tx_count), 5'b0, ac, wi, ri,
                                    4'b0, lb, 1'b0, we, re};
            default: read_data_next = '0;
         endcase
      end
   end

   // FIFO storage (flushed by pointer reset, so no reset needed)
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= req_wbyte;
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_in_byte;
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_write          <= 1'b0;
         lat_be             <= '0;
         lat_word           <= '0;
         lat_wbyte          <= '0;
         lat_ac_clr         <= 1'b0;
         tx_wr_ptr          <= '0;
         tx_rd_ptr          <= '0;
         rx_wr_ptr          <= '0;
         rx_rd_ptr          <= '0;
         tx_count           <= '0;
         rx_count           <= '0;
         re                 <= 1'b0;
         we                 <= 1'b0;
         ac                 <= 1'b0;
`ifdef BRIDGE_UART_LOOPBACK_EN
         lb                 <= 1'b0;
`endif
         irq                <= 1'b0;
         bridge_acknowledge <= 1'b0;
         bridge_read_data   <= '0;
      end else begin
         if (state == S_IDLE && (bridge_read || bridge_write)) begin
            lat_write  <= bridge_write;
            lat_be     <= bridge_byte_enable[1:0];
            lat_word   <= bridge_address[8:2];
            lat_wbyte  <= bridge_write_data[7:0];
            lat_ac_clr <= bridge_write_data[10];
         end
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
         tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
         rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
         if (commit_c && req_write && (req_word == 7'd1) && req_be[0]) begin
            re <= req_wbyte[0];
            we <= req_wbyte[1];
`ifdef BRIDGE_UART_LOOPBACK_EN
            lb <= req_wbyte[3];
`endif
         end
         // A consumed byte wins over a simultaneous clear
         if (tx_pop)
            ac <= 1'b1;
         else if (commit_c && req_write && (req_word == 7'd1) && req_be[1] && req_ac_clr)
            ac <= 1'b0;
         irq                <= ri || wi;
         bridge_acknowledge <= commit_c;
         bridge_read_data   <= read_data_next;
      end
   end
endmodule

// File: tb/tb_bridge_uart_responder.sv
// Scoreboard bench for bridge_uart_responder: one instance with zero wait
// states (64-entry FIFOs) and one with three wait states (4-entry FIFOs).
module tb_bridge_uart_responder;
   typedef struct packed {
      logic        dut;
      logic        rd;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic        b_rd [2];
   logic        b_wr [2];
   logic [3:0]  b_be [2];
   logic [8:0]  b_addr [2];
   logic [31:0] b_wd [2];
   logic        b_ack [2];
   logic [31:0] b_rdata [2];
   logic        prev_ack [2];
   logic [7:0]  tx_data0, tx_data3, rx_data0, rx_data3;
   logic        tx_valid0, tx_valid3, tx_ready0, tx_ready3;
   logic        rx_valid0, rx_valid3, rx_ready0, rx_ready3, irq0, irq3;

   exp_t exp_q[$];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bridge_uart_responder #(.FIFO_DEPTH(64), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset),
      .bridge_read(b_rd[0]), .bridge_write(b_wr[0]), .bridge_byte_enable(b_be[0]),
      .bridge_address(b_addr[0]), .bridge_write_data(b_wd[0]),
      .bridge_acknowledge(b_ack[0]), .bridge_read_data(b_rdata[0]),
      .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
      .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0), .irq(irq0));

   bridge_uart_responder #(.FIFO_DEPTH(4), .WAIT_STATES(3)) dut3 (
      .clk(clk), .reset(reset),
      .bridge_read(b_rd[1]), .bridge_write(b_wr[1]), .bridge_byte_enable(b_be[1]),
      .bridge_address(b_addr[1]), .bridge_write_data(b_wd[1]),
      .bridge_acknowledge(b_ack[1]), .bridge_read_data(b_rdata[1]),
      .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
      .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_ready(rx_ready3), .irq(irq3));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   // One bus transaction; expected response goes to the scoreboard queue
   task automatic txn(input int d, input logic rd, input logic wr, input logic [3:0] be,
                      input logic [8:0] addr, input logic [31:0] wd, input logic [31:0] exp);
      exp_t e;
      int   lat;
      bit   seen;
      e.dut  = 1'(d);
      e.rd   = rd && !wr;
      e.data = exp;
      exp_q.push_back(e);
      @(posedge clk); #1;
      b_rd[d] = rd; b_wr[d] = wr; b_be[d] = be; b_addr[d] = addr; b_wd[d] = wd;
      lat = 0;
      seen = 0;
      while (!seen && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (b_ack[d]) seen = 1;
      end
      b_rd[d] = 1'b0;
      b_wr[d] = 1'b0;
      check($sformatf("ack_latency_d%0d", d), 32'(lat), (d == 0) ? 32'd1 : 32'd4);
   endtask

   task automatic rx_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_valid0 = 1'b1; rx_data0 = b;
      @(posedge clk); #1;
      rx_valid0 = 1'b0;
   endtask

   // Scoreboard monitor: compares on every acknowledge
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            if (b_ack[d]) begin
               check($sformatf("ack_pulse_d%0d", d), 32'(prev_ack[d]), 32'd0);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL ack_unexpected_d%0d: got acknowledge, required none", d);
               end else begin
                  e = exp_q.pop_front();
                  check("ack_dut", 32'(d), 32'(e.dut));
                  if (e.rd) check($sformatf("read_data_d%0d", d), b_rdata[d], e.data);
               end
            end
            prev_ack[d] = b_ack[d];
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         b_rd[d] = 0; b_wr[d] = 0; b_be[d] = 0; b_addr[d] = 0; b_wd[d] = 0; prev_ack[d] = 0;
      end
      tx_ready0 = 0; tx_ready3 = 0; rx_valid0 = 0; rx_valid3 = 0; rx_data0 = 0; rx_data3 = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check("rst_ack", 32'(b_ack[0]), 0);
      check("rst_rdata", b_rdata[0], 0);
      check("rst_irq", 32'(irq0), 0);
      check("rst_tx_valid", 32'(tx_valid0), 0);
      check("rst_rx_ready", 32'(rx_ready0), 1);

      // CONTROL after reset, one TX byte, AC set and cleared
      txn(0, 1, 0, 4'b0000, 9'h004, 0, 32'h0040_0000);
      txn(0, 0, 1, 4'b0001, 9'h000, 32'h41, 0);
      check("tx_valid_after_write", 32'(tx_valid0), 1);
      check("tx_data_after_write", 32'(tx_data0), 32'h41);
      txn(0, 1, 0, 4'b0000, 9'h004, 0, 32'h003F_0000);
      tx_ready0 = 1'b1;
      @(posedge clk); #1;
      tx_ready0 = 1'b0;
      check("tx_valid_after_pop", 32'(tx_valid0), 0);
      txn(0, 1, 0, 4'b0000, 9'h004, 0, 32'h0040_0400);
      txn(0, 0, 1, 4'b0010, 9'h004, 32'h0000_0400, 0);
      txn(0, 1, 0, 4'b0000, 9'h004, 0, 32'h0040_0000);

      // RX path: two bytes then an empty read
      rx_byte(8'h10);
      rx_byte(8'h11);
      txn(0, 1, 0, 4'b0000, 9'h000, 0, 32'h0001_8010);
      txn(0, 1, 0, 4'b0000, 9'h000, 0, 32'h0000_8011);
      txn(0, 1, 0, 4'b0000, 9'h000, 0, 32'h0000_0000);

      // Fill TX, overflow write is dropped, then drain in order
      for (int i = 0; i < 64; i++) txn(0, 0, 1, 4'b0001, 9'h000, 32'(i), 0);
      txn(0, 0, 1, 4'b0001, 9'h000, 32'h0000_00FF, 0);
      txn(0, 1, 0, 4'b0000, 9'h004, 0, 32'h0000_0000);
      tx_ready0 = 1'b1;
      for (int i = 0; i < 64; i++) begin
         check($sformatf("tx_drain_%0d", i), 32'(tx_data0), 32'(i));
         @(posedge clk); #1;
      end
      tx_ready0 = 1'b0;
      check("tx_empty_after_drain", 32'(tx_valid0), 0);

      // RI interrupt rises with a byte and falls one cycle after the popping acknowledge
      txn(0, 0, 1, 4'b0001, 9'h004, 32'h1, 0);
      @(posedge clk); #1;
      check("irq_re_empty", 32'(irq0), 0);
      rx_byte(8'h22);
      @(posedge clk); #1;
      check("irq_ri_set", 32'(irq0), 1);
      txn(0, 1, 0, 4'b0000, 9'h000, 0, 32'h0000_8022);
      check("irq_in_ack_cycle", 32'(irq0), 1);
      @(posedge clk); #1;
      check("irq_after_pop", 32'(irq0), 0);
      txn(0, 0, 1, 4'b0001, 9'h004, 32'h3, 0);
      txn(0, 1, 0, 4'b0000, 9'h004, 0, 32'h0040_0603);
      check("irq_wi", 32'(irq0), 1);
      txn(0, 0, 1, 4'b0001, 9'h004, 32'h0, 0);
      txn(0, 1, 0, 4'b0000, 9'h1FC, 0, 32'h0);

`ifdef BRIDGE_UART_LOOPBACK_EN
      txn(0, 0, 1, 4'b0001, 9'h004, 32'h8, 0);
      txn(0, 1, 0, 4'b0000, 9'h004, 0, 32'h0040_0408);
      txn(0, 0, 1, 4'b0001, 9'h000, 32'h5A, 0);
      check("lb_tx_valid", 32'(tx_valid0), 0);
      check("lb_rx_ready", 32'(rx_ready0), 0);
      txn(0, 1, 0, 4'b0000, 9'h000, 0, 32'h0000_805A);
`endif

      // Three wait states: unmapped read, read+write handled as write
      txn(1, 1, 0, 4'b0000, 9'h1FC, 0, 32'h0);
      txn(1, 1, 1, 4'b0001, 9'h000, 32'h77, 0);
      check("rw_tx_valid", 32'(tx_valid3), 1);
      check("rw_tx_data", 32'(tx_data3), 32'h77);
      txn(1, 1, 0, 4'b0000, 9'h004, 0, 32'h0003_0000);

      repeat (10) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
